// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_STALL    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALT     = 3'd4
    } fetch_state_t;

    // Opcode occupies the top OPC_W bits of the instruction word.
    localparam int          OPC_W   = 4;
    localparam logic [3:0]  HALT_OP = 4'hF;

    function automatic logic is_halt_op(input logic [OPC_W-1:0] opc);
        return (opc == HALT_OP);
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC and decides fetch, stall, redirect or halt each cycle.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 6,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [MEMORY_ADDR_SIZE-1:0] branch_target,
    input  logic [ARQ-1:0]              instr,
    output logic                        pc_en,
    output logic [MEMORY_ADDR_SIZE-1:0] addr_next,
    output logic                        instr_valid,
    output logic                        flush,
    output logic                        halted,
    output logic                        busy,
    output logic [CNT_W-1:0]            fetch_count
);

    fetch_state_t                  state_q, state_d;
    logic [MEMORY_ADDR_SIZE-1:0]   pc_q, pc_d;
    logic                          halt_dec_s;
    logic                          instr_unused_s;

    assign halt_dec_s     = is_halt_op(instr[ARQ-1 -: OPC_W]);
    assign instr_unused_s = ^instr[ARQ-OPC_W-1:0];

    // Next-state, next-PC and per-cycle control outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_en       = 1'b0;
        addr_next   = pc_q;
        flush       = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                instr_valid = 1'b1;
                if (branch_taken) begin
                    instr_valid = 1'b0;
                    pc_en       = 1'b1;
                    addr_next   = branch_target;
                    flush       = 1'b1;
                    pc_d        = branch_target;
                    state_d     = ST_REDIRECT;
                end else if (stall) begin
                    instr_valid = 1'b0;
                    state_d     = ST_STALL;
                end else if (halt_dec_s) begin
                    state_d = ST_HALT;
                end else begin
                    pc_en     = 1'b1;
                    addr_next = pc_q + MEMORY_ADDR_SIZE'(1);
                    pc_d      = pc_q + MEMORY_ADDR_SIZE'(1);
                end
            end
            ST_STALL: begin
                if (branch_taken) begin
                    pc_en     = 1'b1;
                    addr_next = branch_target;
                    flush     = 1'b1;
                    pc_d      = branch_target;
                    state_d   = ST_REDIRECT;
                end else if (!stall) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_STALL;
                end
            end
            // Bubble while memory returns the branch target; requests ignored.
            ST_REDIRECT: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = {MEMORY_ADDR_SIZE{1'b0}};
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= {MEMORY_ADDR_SIZE{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign halted = (state_q == ST_HALT);
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (instr_valid),
        .count_o (fetch_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [15:0] instr;
    logic        pc_en;
    logic [5:0]  addr_next;
    logic        instr_valid;
    logic        flush;
    logic        halted;
    logic        busy;
    logic [15:0] fetch_count;

    int n_checks;
    int n_fail;
    int exp_cnt;

    fetch_ctrl #(.ARQ(16), .MEMORY_ADDR_SIZE(6), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .pc_en         (pc_en),
        .addr_next     (addr_next),
        .instr_valid   (instr_valid),
        .flush         (flush),
        .halted        (halted),
        .busy          (busy),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the six control outputs: {pc_en, instr_valid, flush, halted, busy, addr_next}
    function automatic logic [10:0] ctl();
        return {pc_en, instr_valid, flush, halted, busy, addr_next};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 6'd0; instr = 16'h0000;
        #1;
        n_checks++;
        if (ctl() !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp %h", ctl(), 11'd0);
        end
        tick(); tick();
        n_checks++;
        if (fetch_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %h exp %h", fetch_count, 16'd0);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [5:0] exp_a;
        start = 1'b1;
        #1;
        n_checks++;
        if (ctl() !== 11'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h exp %h", ctl(), 11'd0);
        end
        tick();
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            exp_a = 6'(k);
            #1;
            n_checks++;
            if (ctl() !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_a}) begin
                n_fail++;
                $display("FAIL seq_fetch_%0d: got %h exp %h", k, ctl(), {5'b11001, exp_a});
            end
            tick();
        end
        exp_cnt = 64;
        n_checks++;
        if (fetch_count !== 16'd64) begin
            n_fail++; $display("FAIL seq_count: got %0d exp %0d", fetch_count, 64);
        end
    endtask

    task automatic test_stall();
        repeat (5) tick();
        exp_cnt += 5;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 1'b0;
            #1;
            n_checks++;
            if ({pc_en, instr_valid, fetch_count} !== {2'b00, 16'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL stall_cycle_%0d: pc_en=%b valid=%b cnt=%0d exp 0 0 %0d",
                         k, pc_en, instr_valid, fetch_count, exp_cnt);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({pc_en, instr_valid, addr_next} !== {2'b11, 6'd6}) begin
            n_fail++; $display("FAIL stall_resume: got %b %b %0d exp 1 1 6", pc_en, instr_valid, addr_next);
        end
        tick();
        exp_cnt += 1;
    endtask

    task automatic test_branch();
        tick();
        exp_cnt += 1;
        branch_taken = 1'b1; branch_target = 6'h20;
        #1;
        n_checks++;
        if (ctl() !== {5'b10101, 6'h20}) begin
            n_fail++; $display("FAIL branch_cycle: got %h exp %h", ctl(), {5'b10101, 6'h20});
        end
        tick();
        stall = 1'b1; branch_target = 6'h05;
        #1;
        n_checks++;
        if ({pc_en, instr_valid, flush, busy} !== 4'b0001) begin
            n_fail++; $display("FAIL redirect_bubble: got %b exp 0001", {pc_en, instr_valid, flush, busy});
        end
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        n_checks++;
        if (ctl() !== {5'b11001, 6'h21}) begin
            n_fail++; $display("FAIL branch_resume: got %h exp %h", ctl(), {5'b11001, 6'h21});
        end
        tick();
        exp_cnt += 1;
    endtask

    task automatic test_branch_in_stall();
        stall = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 6'h10;
        #1;
        n_checks++;
        if (ctl() !== {5'b10101, 6'h10}) begin
            n_fail++; $display("FAIL stall_branch: got %h exp %h", ctl(), {5'b10101, 6'h10});
        end
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        n_checks++;
        if ({pc_en, instr_valid, flush} !== 3'b000) begin
            n_fail++; $display("FAIL stall_branch_bubble: got %b exp 000", {pc_en, instr_valid, flush});
        end
        tick();
        #1;
        n_checks++;
        if (ctl() !== {5'b11001, 6'h11}) begin
            n_fail++; $display("FAIL stall_branch_resume: got %h exp %h", ctl(), {5'b11001, 6'h11});
        end
        tick();
        exp_cnt += 1;
    endtask

    task automatic test_halt();
        instr = 16'hF000;
        #1;
        n_checks++;
        if ({pc_en, instr_valid, halted} !== 3'b010) begin
            n_fail++; $display("FAIL halt_decode: got %b exp 010", {pc_en, instr_valid, halted});
        end
        tick();
        exp_cnt += 1;
        instr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            start = (k != 1);
            #1;
            n_checks++;
            if ({ctl(), fetch_count} !== {5'b00010, 6'h11, 16'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got %h cnt %0d exp %h cnt %0d",
                         k, ctl(), fetch_count, {5'b00010, 6'h11}, exp_cnt);
            end
            tick();
        end
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ctl(), fetch_count} !== 27'd0) begin
            n_fail++; $display("FAIL halt_reset: got %h cnt %0d exp 0", ctl(), fetch_count);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        n_checks++;
        if ({pc_en, addr_next, fetch_count} !== {1'b1, 6'd4, 16'd3}) begin
            n_fail++; $display("FAIL pre_reset: got %b %0d %0d exp 1 4 3", pc_en, addr_next, fetch_count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ctl(), fetch_count} !== 27'd0) begin
            n_fail++; $display("FAIL async_reset: got %h cnt %0d exp 0", ctl(), fetch_count);
        end
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_checks++;
        if (ctl() !== {5'b11001, 6'd1}) begin
            n_fail++; $display("FAIL restart_after_reset: got %h exp %h", ctl(), {5'b11001, 6'd1});
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        n_checks++;
        if (fetch_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_near_max: got %h exp %h", fetch_count, 16'hFFFE);
        end
        tick();
        n_checks++;
        if (fetch_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_max: got %h exp %h", fetch_count, 16'hFFFF);
        end
        repeat (3) tick();
        n_checks++;
        if ({fetch_count, instr_valid} !== {16'hFFFF, 1'b1}) begin
            n_fail++; $display("FAIL sat_hold: got %h valid %b exp ffff 1", fetch_count, instr_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_in_stall();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
